// File: rtl/mem_bus_unit.sv
// mem_bus_unit: memory-mapped bus glue between a processor, a synchronous RAM and LED/HEX/switch I/O.
// The processor is stalled for one cycle whenever it presents a new RAM address, so the RAM read lands in time.
module mem_bus_unit (
    input  logic        Clock,
    input  logic        reset,
    input  logic        run_req,
    input  logic [15:0] addr_in,
    input  logic [15:0] data_wr,
    input  logic        Wr,
    input  logic [9:0]  sw,
    input  logic [15:0] ram_rdata,
    output logic        run,
    output logic [15:0] data_rd,
    output logic [6:0]  ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    output logic [9:0]  ledr,
    output logic [15:0] hex_val,
    output logic        bus_err
);
    localparam logic [1:0] HALT = 2'd0, WAIT = 2'd1, RUN = 2'd2;
    logic [1:0]  state, state_nx;
    logic        run_q, run_s;
    logic [9:0]  sw_q, sw_s;
    logic [15:0] addr_q;
    logic        is_ram, is_ledr, is_sw, is_hex, is_unm, commit;
    assign is_ram    = addr_in[15:7] == 9'd0;
    assign is_ledr   = addr_in == 16'h1000;
    assign is_sw     = addr_in == 16'h2000;
    assign is_hex    = addr_in == 16'h3000;
    assign is_unm    = !(is_ram || is_ledr || is_sw || is_hex);
    assign run       = state == RUN;
    assign commit    = run && Wr;
    assign ram_addr  = addr_in[6:0];
    assign ram_wdata = data_wr;
    assign ram_we    = commit && is_ram;
    assign data_rd   = is_ram  ? ram_rdata :
                       is_sw   ? {6'b0, sw_s} :
                       is_ledr ? {6'b0, ledr} :
                       is_hex  ? hex_val : 16'h0000;
    // Only a fresh RAM address needs a stall; I/O registers answer combinationally.
    always_comb
        state_nx = !run_s                                        ? HALT :
                   state == HALT                                 ? WAIT :
                   (state == RUN && addr_in != addr_q && is_ram) ? WAIT :
                   state == WAIT                                 ? RUN  : state;
    always_ff @(posedge Clock or negedge reset)
        if (!reset) begin
            run_q   <= 1'b0;
            run_s   <= 1'b0;
            sw_q    <= '0;
            sw_s    <= '0;
            state   <= HALT;
            addr_q  <= '0;
            ledr    <= '0;
            hex_val <= '0;
            bus_err <= 1'b0;
        end else begin
            run_q  <= run_req;
            run_s  <= run_q;
            sw_q   <= sw;
            sw_s   <= sw_q;
            state  <= state_nx;
            addr_q <= addr_in;
            if (commit && is_ledr)
                ledr <= data_wr[9:0];
            if (commit && is_hex)
                hex_val <= data_wr;
            if (run && (is_unm || (Wr && is_sw)))
                bus_err <= 1'b1;
        end
endmodule

// File: tb/tb_mem_bus_unit.sv
// tb_mem_bus_unit: directed and randomized checks of mem_bus_unit against a transaction-level model
// of the address map, the one-cycle RAM stall and the sticky bus error.
module tb_mem_bus_unit;
    logic        Clock = 1'b0;
    logic        reset, run_req, Wr;
    logic [15:0] addr_in, data_wr, ram_rdata;
    logic [9:0]  sw;
    logic        run, ram_we, bus_err;
    logic [15:0] data_rd, ram_wdata, hex_val;
    logic [6:0]  ram_addr;
    logic [9:0]  ledr;
    int          n_checks = 0, n_fail = 0;
    logic [15:0] mem [128];
    logic [15:0] exp_mem [128];
    logic [9:0]  exp_ledr, sw_val;
    logic [15:0] exp_hex, prev_a;
    logic        exp_err;

    mem_bus_unit dut (
        .Clock(Clock), .reset(reset), .run_req(run_req), .addr_in(addr_in), .data_wr(data_wr),
        .Wr(Wr), .sw(sw), .ram_rdata(ram_rdata), .run(run), .data_rd(data_rd), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ledr(ledr), .hex_val(hex_val), .bus_err(bus_err)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    function automatic logic unm(input logic [15:0] a);
        return !(a[15:7] == 9'd0 || a == 16'h1000 || a == 16'h2000 || a == 16'h3000);
    endfunction

    function automatic logic [15:0] exp_read(input logic [15:0] a);
        if (a[15:7] == 9'd0) return exp_mem[a[6:0]];
        if (a == 16'h1000) return {6'b0, exp_ledr};
        if (a == 16'h2000) return {6'b0, sw_val};
        if (a == 16'h3000) return exp_hex;
        return 16'h0000;
    endfunction

    // One processor access starting from RUN: a new RAM address costs exactly one stall cycle.
    task automatic access(input logic [15:0] a, input logic w, input logic [15:0] d);
        logic ram, stall;
        ram = a[15:7] == 9'd0;
        stall = ram && a != prev_a;
        addr_in = a; Wr = w; data_wr = d;
        #1;
        n_checks++;
        if (run !== 1'b1) begin n_fail++; $display("FAIL acc_run_pre a=%h got %b want 1", a, run); end
        n_checks++;
        if (ram_we !== (w && ram)) begin n_fail++; $display("FAIL acc_we a=%h got %b want %b", a, ram_we, w && ram); end
        if (w && ram) begin
            n_checks++;
            if (ram_wdata !== d) begin n_fail++; $display("FAIL acc_wdata a=%h got %h want %h", a, ram_wdata, d); end
        end
        @(posedge Clock); #1;
        if (w) begin
            if (ram) exp_mem[a[6:0]] = d;
            else if (a == 16'h1000) exp_ledr = d[9:0];
            else if (a == 16'h3000) exp_hex = d;
            else exp_err = 1'b1;
        end else if (unm(a)) exp_err = 1'b1;
        Wr = 1'b0;
        prev_a = a;
        if (stall) begin
            n_checks++;
            if (run !== 1'b0) begin n_fail++; $display("FAIL acc_stall a=%h got %b want 0", a, run); end
            @(posedge Clock); #1;
        end
        n_checks++;
        if (run !== 1'b1) begin n_fail++; $display("FAIL acc_run_post a=%h got %b want 1", a, run); end
        if (!w) begin
            n_checks++;
            if (data_rd !== exp_read(a)) begin n_fail++; $display("FAIL acc_rd a=%h got %h want %h", a, data_rd, exp_read(a)); end
        end
        n_checks++;
        if (ledr !== exp_ledr) begin n_fail++; $display("FAIL acc_ledr got %h want %h", ledr, exp_ledr); end
        n_checks++;
        if (hex_val !== exp_hex) begin n_fail++; $display("FAIL acc_hex got %h want %h", hex_val, exp_hex); end
        n_checks++;
        if (bus_err !== exp_err) begin n_fail++; $display("FAIL acc_err a=%h got %b want %b", a, bus_err, exp_err); end
    endtask

    task automatic test_reset();
        reset = 1'b0; run_req = 1'b1; Wr = 1'b1; addr_in = 16'h0010; data_wr = 16'hFFFF; sw = sw_val;
        #1;
        n_checks++;
        if ({run, ram_we, bus_err} !== 3'b000) begin n_fail++; $display("FAIL rst_async run/we/err got %b want 000", {run, ram_we, bus_err}); end
        @(posedge Clock); #1;
        n_checks++;
        if ({run, ram_we} !== 2'b00) begin n_fail++; $display("FAIL rst_hold run/we got %b want 00", {run, ram_we}); end
        n_checks++;
        if (ledr !== 10'd0 || hex_val !== 16'd0 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_regs ledr=%h hex=%h err=%b want 0", ledr, hex_val, bus_err);
        end
        Wr = 1'b0; addr_in = 16'h0000;
        exp_ledr = '0; exp_hex = '0; exp_err = 1'b0; prev_a = 16'h0000;
        reset = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge Clock); #1;
            n_checks++;
            if (run !== (e == 4)) begin n_fail++; $display("FAIL rst_edge%0d run got %b want %b", e, run, e == 4); end
        end
    endtask

    task automatic test_ram_stall();
        access(16'h0005, 1'b0, 16'h0);
        access(16'h0006, 1'b0, 16'h0);
        n_checks++;
        if (data_rd !== 16'hBEEF) begin n_fail++; $display("FAIL stall_beef got %h want beef", data_rd); end
    endtask

    task automatic test_ledr_write();
        access(16'h1000, 1'b1, 16'h03FF);
        n_checks++;
        if (ledr !== 10'h3FF) begin n_fail++; $display("FAIL ledr_write got %h want 3ff", ledr); end
    endtask

    task automatic test_ram_write();
        access(16'h0010, 1'b1, 16'h1234);
        access(16'h3000, 1'b1, 16'hA5C3);
        access(16'h0010, 1'b0, 16'h0);
        n_checks++;
        if (data_rd !== 16'h1234) begin n_fail++; $display("FAIL ram_readback got %h want 1234", data_rd); end
    endtask

    // Drop run_req early enough that it is seen while the unit sits in WAIT.
    task automatic test_run_drop();
        run_req = 1'b0;
        @(posedge Clock); #1;
        addr_in = 16'h0020;
        @(posedge Clock); #1;
        n_checks++;
        if (run !== 1'b0) begin n_fail++; $display("FAIL drop_wait run got %b want 0", run); end
        Wr = 1'b1; data_wr = 16'h0155;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (ram_we !== 1'b0 || ledr !== exp_ledr || hex_val !== exp_hex) begin
                n_fail++; $display("FAIL drop_store%0d we=%b ledr=%h hex=%h want 0 %h %h", i, ram_we, ledr, hex_val, exp_ledr, exp_hex);
            end
            @(posedge Clock); #1;
            n_checks++;
            if (run !== 1'b0) begin n_fail++; $display("FAIL drop_stall%0d run got %b want 0", i, run); end
            if (i == 0) run_req = 1'b1;
        end
        @(posedge Clock); #1;
        n_checks++;
        if (run !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 16'h0155) begin
            n_fail++; $display("FAIL drop_resume run=%b we=%b wdata=%h want 1 1 0155", run, ram_we, ram_wdata);
        end
        @(posedge Clock); #1;
        exp_mem[7'h20] = 16'h0155;
        Wr = 1'b0;
        prev_a = 16'h0020;
        access(16'h0020, 1'b0, 16'h0);
    endtask

    task automatic test_bus_err();
        access(16'h4000, 1'b0, 16'h0);
        n_checks++;
        if (data_rd !== 16'h0000 || bus_err !== 1'b1) begin
            n_fail++; $display("FAIL err_unmapped rd=%h err=%b want 0000 1", data_rd, bus_err);
        end
        access(16'h0000, 1'b0, 16'h0);
        n_checks++;
        if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", bus_err); end
    endtask

    task automatic test_random();
        logic [15:0] a;
        sw_val = 10'($urandom);
        sw = sw_val;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            if (unm(prev_a)) exp_err = 1'b1;
        end
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0, 1: a = {9'd0, 7'($urandom)};
                2: a = 16'h1000;
                3: a = 16'h2000;
                4: a = 16'h3000;
                default: begin
                    a = 16'($urandom_range(16'h0080, 16'hFFFF));
                    while (!unm(a)) a = 16'($urandom_range(16'h0080, 16'hFFFF));
                end
            endcase
            access(a, 1'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 16'($urandom);
            exp_mem[i] = mem[i];
        end
        mem[6] = 16'hBEEF;
        exp_mem[6] = 16'hBEEF;
        sw_val = 10'h2A5;
        test_reset();
        test_ram_stall();
        test_ledr_write();
        test_ram_write();
        test_run_drop();
        test_bus_err();
        test_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
